// File: rtl/ip2_test_sequencer_if.sv
// ----------------------------------------------------------------------------
// ip2_test_sequencer_if : control/status bundle between software, test FSMs
//                         and the ip2 test sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ip2_test_sequencer_if #(
  parameter int NUM_TESTS = 4,
  parameter int TIMEOUT_W = 20
);
  logic [5:0]           test_delay;
  logic                 start;
  logic                 abort;
  logic [NUM_TESTS-1:0] test_mask;
  logic [TIMEOUT_W-1:0] timeout_max;
  logic [NUM_TESTS-1:0] test_done;

  logic [5:0]           clk_counter;
  logic [NUM_TESTS-1:0] test_enable;
  logic                 test_enable_re;
  logic [3:0]           active_test;
  logic                 busy;
  logic                 seq_done;
  logic                 seq_error;
  logic [NUM_TESTS-1:0] fail_vec;

  modport master (
    output test_delay, start, abort, test_mask, timeout_max, test_done,
    input  clk_counter, test_enable, test_enable_re, active_test,
           busy, seq_done, seq_error, fail_vec
  );

  modport slave (
    input  test_delay, start, abort, test_mask, timeout_max, test_done,
    output clk_counter, test_enable, test_enable_re, active_test,
           busy, seq_done, seq_error, fail_vec
  );
endinterface

`default_nettype wire

// File: rtl/ip2_test_sequencer.sv
// ----------------------------------------------------------------------------
// ip2_test_sequencer : grants the shared scan resource to one masked test FSM
//                      at a time, with per-test timeout and pass/fail report.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ip2_test_sequencer #(
  parameter int NUM_TESTS = 4,
  parameter int TIMEOUT_W = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  ip2_test_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_ARM     = 3'd2,
    S_TRIGGER = 3'd3,
    S_WAIT    = 3'd4,
    S_RELEASE = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  state_t               r_state;
  logic [NUM_TESTS-1:0] r_remaining;
  logic [TIMEOUT_W-1:0] r_tcnt;

  logic [NUM_TESTS-1:0] w_sel_onehot;
  logic [3:0]           w_sel_idx;
  logic                 w_done_sel;

  // Isolate the lowest pending test; grant order is ascending index.
  assign w_sel_onehot = r_remaining & (~r_remaining + NUM_TESTS'(1));

  always_comb begin
    w_sel_idx = '0;
    for (int k = 0; k < NUM_TESTS; k++) begin
      if (w_sel_onehot[k]) w_sel_idx = 4'(k);
    end
  end

  // Masking with the one-hot grant drops done bits from non-granted tests.
  assign w_done_sel = |(bus.test_done & bus.test_enable);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.clk_counter <= '0;
    end else if (bus.clk_counter >= bus.test_delay) begin
      bus.clk_counter <= '0;
    end else begin
      bus.clk_counter <= bus.clk_counter + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_remaining        <= '0;
      r_tcnt             <= '0;
      bus.test_enable    <= '0;
      bus.test_enable_re <= 1'b0;
      bus.active_test    <= '0;
      bus.busy           <= 1'b0;
      bus.seq_done       <= 1'b0;
      bus.seq_error      <= 1'b0;
      bus.fail_vec       <= '0;
    end else begin
      bus.test_enable_re <= 1'b0;
      if (bus.abort && (r_state != S_IDLE)) begin
        r_state         <= S_IDLE;
        r_remaining     <= '0;
        bus.test_enable <= '0;
        bus.active_test <= '0;
        bus.busy        <= 1'b0;
        bus.seq_error   <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              r_remaining   <= bus.test_mask;
              bus.seq_done  <= 1'b0;
              bus.seq_error <= 1'b0;
              bus.fail_vec  <= '0;
              bus.busy      <= 1'b1;
              r_state       <= (bus.test_mask == '0) ? S_FINISH : S_SELECT;
            end
          end
          S_SELECT: begin
            r_remaining     <= r_remaining & ~w_sel_onehot;
            bus.active_test <= w_sel_idx;
            bus.test_enable <= w_sel_onehot;
            r_state         <= S_ARM;
          end
          S_ARM: begin
            r_state <= S_TRIGGER;
          end
          S_TRIGGER: begin
            bus.test_enable_re <= 1'b1;
            r_tcnt             <= '0;
            r_state            <= S_WAIT;
          end
          S_WAIT: begin
            r_tcnt <= r_tcnt + TIMEOUT_W'(1);
            // The first two WAIT cycles may still see the previous run's done.
            if ((r_tcnt >= TIMEOUT_W'(2)) && w_done_sel) begin
              r_state <= S_RELEASE;
            end else if (r_tcnt == bus.timeout_max) begin
              bus.fail_vec  <= bus.fail_vec | bus.test_enable;
              bus.seq_error <= 1'b1;
              r_state       <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            bus.test_enable <= '0;
            bus.active_test <= '0;
            r_state         <= (r_remaining != '0) ? S_SELECT : S_FINISH;
          end
          S_FINISH: begin
            bus.busy     <= 1'b0;
            bus.seq_done <= 1'b1;
            r_state      <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ip2_test_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ip2_test_sequencer : directed self-checking bench for ip2_test_sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/100ps

module tb_ip2_test_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       auto_en = 1'b0;
  logic [3:0] man_done = '0;
  logic [3:0] man_pulse = '0;
  logic [3:0] pulse_bits = '0;
  logic [3:0] model_done = '0;
  int         lat [4];
  int         mcnt [4];

  int n_checks = 0;
  int n_errors = 0;

  int         n_re, re_cyc, drop_cyc, fail_cyc, done_cyc, n_log;
  logic       onehot_bad;
  logic [3:0] en_log [8];

  always #1.25 clk = ~clk;

  ip2_test_sequencer_if #(.NUM_TESTS(4), .TIMEOUT_W(20)) sif ();

  ip2_test_sequencer #(.NUM_TESTS(4), .TIMEOUT_W(20)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (sif)
  );

  assign sif.test_done = auto_en ? model_done : (man_done | man_pulse);

  // Test FSM stand-in: raises done lat[i] cycles after its re, holds it while enabled.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || !sif.test_enable[i]) begin
        mcnt[i]       <= 0;
        model_done[i] <= 1'b0;
      end else if (sif.test_enable_re) begin
        mcnt[i] <= 1;
      end else if (mcnt[i] != 0) begin
        if (mcnt[i] == lat[i]) model_done[i] <= 1'b1;
        else mcnt[i] <= mcnt[i] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a sequence from a negedge and follows it to seq_done (bounded).
  task automatic run_seq(input logic [3:0] mask, input int restart_at, input int pulse_rel);
    logic [3:0] prev_en;
    prev_en = sif.test_enable;
    n_re = 0; re_cyc = -1; drop_cyc = -1; fail_cyc = -1; done_cyc = -1;
    n_log = 0; onehot_bad = 1'b0;
    sif.test_mask = mask;
    sif.start = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      sif.start = (cyc == restart_at);
      man_pulse = '0;
      if (sif.test_enable_re) begin
        n_re++;
        re_cyc = cyc;
      end
      if (pulse_rel > 0 && re_cyc > 0 && cyc == re_cyc + pulse_rel) man_pulse = pulse_bits;
      if ($countones(sif.test_enable) > 1) onehot_bad = 1'b1;
      if (sif.test_enable != prev_en) begin
        if (n_log < 8) en_log[n_log] = sif.test_enable;
        n_log++;
        if (sif.test_enable == '0) drop_cyc = cyc;
        prev_en = sif.test_enable;
      end
      if (fail_cyc < 0 && sif.fail_vec != '0) fail_cyc = cyc;
      if (sif.seq_done) begin
        done_cyc = cyc;
        break;
      end
    end
    sif.start = 1'b0;
    man_pulse = '0;
  endtask

  initial begin
    logic found, later;
    sif.test_delay  = 6'd5;
    sif.start       = 1'b0;
    sif.abort       = 1'b0;
    sif.test_mask   = '0;
    sif.timeout_max = 20'd1000;
    for (int i = 0; i < 4; i++) lat[i] = 10;

    repeat (3) @(negedge clk);
    check_eq("rst_enable", sif.test_enable, 0);
    check_eq("rst_re", sif.test_enable_re, 0);
    check_eq("rst_active", sif.active_test, 0);
    check_eq("rst_busy", sif.busy, 0);
    check_eq("rst_flags", {sif.seq_done, sif.seq_error, sif.fail_vec}, 0);
    check_eq("rst_cnt", sif.clk_counter, 0);
    rst = 1'b0;

    // clk_counter: 0..5 wrap, then lower the terminal value mid-count, then hold.
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_eq("cnt_seq", sif.clk_counter, k % 6);
    end
    for (int k = 0; k < 20 && sif.clk_counter != 6'd4; k++) @(negedge clk);
    check_eq("cnt_at4", sif.clk_counter, 4);
    sif.test_delay = 6'd2;
    @(negedge clk); check_eq("cnt_lower_wrap", sif.clk_counter, 0);
    @(negedge clk); check_eq("cnt_d2_a", sif.clk_counter, 1);
    @(negedge clk); check_eq("cnt_d2_b", sif.clk_counter, 2);
    @(negedge clk); check_eq("cnt_d2_c", sif.clk_counter, 0);
    sif.test_delay = 6'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("cnt_d0_hold", sif.clk_counter, 0);
    end
    sif.test_delay = 6'd3;

    // Empty mask: seq_done on the second negedge after start, no re pulse.
    run_seq(4'b0000, 0, 0);
    check_eq("empty_done_cyc", done_cyc, 2);
    check_eq("empty_no_re", n_re, 0);
    check_eq("empty_busy_off", sif.busy, 0);

    // Mask 0101 with passing tests.
    auto_en = 1'b1; lat[0] = 10; lat[2] = 20;
    run_seq(4'b0101, 0, 0);
    check_eq("m5_nlog", n_log, 4);
    check_eq("m5_en_seq", {en_log[0], en_log[1], en_log[2], en_log[3]}, 16'h1040);
    check_eq("m5_re_cnt", n_re, 2);
    check_eq("m5_onehot", onehot_bad, 0);
    check_eq("m5_done", sif.seq_done, 1);
    check_eq("m5_fail_vec", sif.fail_vec, 0);
    check_eq("m5_error", sif.seq_error, 0);

    // Single test lat=10: start -> SELECT, ARM, TRIGGER, done at tcnt 11, RELEASE, FINISH = 18.
    lat[0] = 10;
    repeat (2) @(negedge clk);
    run_seq(4'b0001, 3, 0);
    check_eq("restart_ignored_cyc", done_cyc, 18);
    check_eq("restart_ignored_re", n_re, 1);

    // Timeout: counter runs 0..50 in WAIT, fail_vec rises 51 samples after re.
    auto_en = 1'b0; man_done = '0; sif.timeout_max = 20'd50;
    repeat (2) @(negedge clk);
    run_seq(4'b0010, 0, 0);
    check_eq("to_latency", fail_cyc - re_cyc, 51);
    check_eq("to_fail_vec", sif.fail_vec, 4'b0010);
    check_eq("to_error", sif.seq_error, 1);
    check_eq("to_done", sif.seq_done, 1);

    // Stale done held high: accepted only at tcnt 2, grant drops 4 samples after re.
    man_done = 4'b0010; sif.timeout_max = 20'd30;
    repeat (2) @(negedge clk);
    run_seq(4'b0010, 0, 0);
    check_eq("stale_drop", drop_cyc - re_cyc, 4);
    check_eq("stale_pass", {sif.seq_error, sif.fail_vec}, 0);

    // Done pulse at tcnt 1 only, other tests' done bits high: still a timeout.
    man_done = 4'b1001; pulse_bits = 4'b0010; sif.timeout_max = 20'd20;
    repeat (2) @(negedge clk);
    run_seq(4'b0010, 0, 1);
    check_eq("early_pulse_fail", sif.fail_vec, 4'b0010);
    check_eq("early_pulse_err", sif.seq_error, 1);
    check_eq("early_pulse_lat", fail_cyc - re_cyc, 21);

    // Abort during WAIT of the second test.
    auto_en = 1'b1; man_done = '0; lat[0] = 5; lat[1] = 40; sif.timeout_max = 20'd1000;
    sif.test_mask = 4'b1111; sif.start = 1'b1; found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      sif.start = 1'b0;
      if (sif.test_enable == 4'b0010 && sif.test_enable_re) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("abort_reach_t1", found, 1);
    repeat (5) @(negedge clk);
    check_eq("abort_pre_err", sif.seq_error, 0);
    sif.abort = 1'b1;
    @(negedge clk);
    sif.abort = 1'b0;
    check_eq("abort_enable", sif.test_enable, 0);
    check_eq("abort_active", sif.active_test, 0);
    check_eq("abort_busy", sif.busy, 0);
    check_eq("abort_error", sif.seq_error, 1);
    check_eq("abort_no_done", sif.seq_done, 0);
    later = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (sif.test_enable != '0 || sif.test_enable_re) later = 1'b1;
    end
    check_eq("abort_no_grants", later, 0);

    // Asynchronous reset in the middle of WAIT.
    auto_en = 1'b0;
    sif.test_mask = 4'b0001; sif.start = 1'b1; found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      sif.start = 1'b0;
      if (sif.test_enable_re) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("arst_reach_wait", found, 1);
    repeat (3) @(negedge clk);
    check_eq("arst_pre_enable", sif.test_enable, 4'b0001);
    #0.3 rst = 1'b1;
    #0.2;
    check_eq("arst_enable", sif.test_enable, 0);
    check_eq("arst_busy", sif.busy, 0);
    check_eq("arst_cnt", sif.clk_counter, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
